alu_sequencer: RTL and testbench

- Issue/writeback controller that drives the shared 8-bit ALU (registered, 1-cycle latency).
- Fetches 16-bit instruction words, decodes them, and issues opcode/operands to the ALU.
- Captures the ALU result back into accumulators A/B, or forwards it to data memory.
- Sits between instruction memory, data memory and the ALU. It is the initiator side of the ALU opcode/in1/in2/rWrData interface.

---
 rtl/alu_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issue/writeback controller for the shared 8-bit ALU: fetches 16-bit instructions,
// issues them to the registered ALU and writes results to A/B or data memory.
module alu_sequencer #(
  parameter int unsigned         PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] PC_RESET = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [9:0]          dmem_addr,
  output logic [7:0]          dmem_wdata,
  input  logic                dmem_ack,
  input  logic [7:0]          dmem_rdata,
  output logic [5:0]          alu_opcode,
  output logic [9:0]          alu_in1,
  output logic [9:0]          alu_in2,
  input  logic [7:0]          alu_result,
  output logic [7:0]          reg_a,
  output logic [7:0]          reg_b,
  output logic [PC_WIDTH-1:0] pc,
  output logic                illegal
);

  localparam logic [5:0] OpNop  = 6'h00;
  localparam logic [5:0] OpLdca = 6'h01;
  localparam logic [5:0] OpLdcb = 6'h02;
  localparam logic [5:0] OpLda  = 6'h03;
  localparam logic [5:0] OpLdb  = 6'h04;
  localparam logic [5:0] OpSta  = 6'h05;
  localparam logic [5:0] OpStb  = 6'h06;
  localparam logic [5:0] OpAdda = 6'h07;
  localparam logic [5:0] OpAddb = 6'h08;

  localparam logic [PC_WIDTH-1:0] PcOne = PC_WIDTH'(1);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StWb, StMem} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [15:0]         ir_q;
  logic [7:0]          a_q, b_q, dmem_wdata_q;
  logic                imem_req_q, imem_req_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, illegal_q;
  logic [5:0]          alu_opcode_q, alu_opcode_d;

  logic [5:0] op;
  logic [9:0] operand;
  logic       op_legal, op_mem, op_store;

  assign op       = ir_q[15:10];
  assign operand  = ir_q[9:0];
  assign op_legal = op inside {OpNop, OpLdca, OpLdcb, OpLda, OpLdb, OpSta, OpStb, OpAdda, OpAddb};
  assign op_mem   = op inside {OpLda, OpLdb, OpSta, OpStb};
  assign op_store = op inside {OpSta, OpStb};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (imem_req_q && imem_ack) state_d = StDecode;
      StDecode: state_d = StExec;
      StExec:   state_d = StWb;
      StWb:     state_d = op_mem ? StMem : StFetch;
      StMem:    if (dmem_ack) state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Output flops load the value for the state being entered, so requests and the
  // ALU opcode line up with the state they belong to.
  always_comb begin
    imem_req_d   = (state_d == StFetch);
    dmem_req_d   = (state_d == StMem);
    alu_opcode_d = (state_d == StExec && op_legal) ? op : OpNop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= PC_RESET;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      dmem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      alu_opcode_q <= OpNop;
      illegal_q    <= 1'b0;
    end else begin
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      alu_opcode_q <= alu_opcode_d;
      if (state_q == StFetch && imem_req_q && imem_ack) ir_q <= imem_data;
      if (state_q == StDecode && !op_legal) illegal_q <= 1'b1;
      if (state_q == StWb) begin
        case (op)
          OpLdca:        a_q <= operand[7:0];
          OpLdcb:        b_q <= operand[7:0];
          OpAdda:        a_q <= alu_result;
          OpAddb:        b_q <= alu_result;
          OpSta, OpStb:  dmem_wdata_q <= alu_result;
          default:       ;
        endcase
        if (op_mem) dmem_we_q <= op_store;
        else        pc_q <= pc_q + PcOne;
      end
      if (state_q == StMem && dmem_ack) begin
        if (op == OpLda) a_q <= dmem_rdata;
        if (op == OpLdb) b_q <= dmem_rdata;
        pc_q <= pc_q + PcOne;
      end
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = operand;
  assign dmem_wdata = dmem_wdata_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_in1    = {2'b00, a_q};
  assign alu_in2    = {2'b00, b_q};
  assign reg_a      = a_q;
  assign reg_b      = b_q;
  assign pc         = pc_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: an ISA-level model predicts fetch-time state,
// ALU issues and data-memory transactions; monitors compare as the DUT produces them.
module tb_alu_sequencer;

  localparam logic [5:0] NOP  = 6'h00;
  localparam logic [5:0] LDCA = 6'h01;
  localparam logic [5:0] LDCB = 6'h02;
  localparam logic [5:0] LDA  = 6'h03;
  localparam logic [5:0] LDB  = 6'h04;
  localparam logic [5:0] STA  = 6'h05;
  localparam logic [5:0] STB  = 6'h06;
  localparam logic [5:0] ADDA = 6'h07;
  localparam logic [5:0] ADDB = 6'h08;
  localparam int K = 1030;

  typedef struct { logic [9:0] pc; logic [7:0] a; logic [7:0] b; logic ill; int gap; } fetch_t;
  typedef struct { logic we; logic [9:0] addr; logic [7:0] wdata; } dmem_t;
  typedef struct { logic [5:0] op; logic [7:0] a; logic [7:0] b; } alu_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, illegal;
  logic [9:0]  imem_addr, dmem_addr, alu_in1, alu_in2, pc;
  logic [15:0] imem_data;
  logic [7:0]  dmem_wdata, dmem_rdata, reg_a, reg_b;
  logic [7:0]  alu_result = 8'h00;
  logic [5:0]  alu_opcode;

  alu_sequencer #(.PC_WIDTH(10), .PC_RESET(10'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .alu_opcode (alu_opcode),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_result (alu_result),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .pc         (pc),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Registered ALU, one cycle of latency.
  always @(posedge clk) begin
    case (alu_opcode)
      ADDA, ADDB: alu_result <= alu_in1[7:0] + alu_in2[7:0];
      STA:        alu_result <= alu_in1[7:0];
      STB:        alu_result <= alu_in2[7:0];
      default:    alu_result <= 8'h00;
    endcase
  end

  logic [15:0] prog [1024];
  logic [7:0]  dmem_mem [1024];
  logic [7:0]  ref_mem [1024];
  int          dstall [2048];
  int          dcnt = 0;
  bit          zero_stall = 0;
  bit          mon_en = 0;
  int          total = 0, bad = 0;
  int          cyc = 0, last_fetch = 0, fetched = 0;
  logic [5:0]  legal_ops [9] = '{NOP, LDCA, LDCB, LDA, LDB, STA, STB, ADDA, ADDB};

  fetch_t exp_fetch[$];
  dmem_t  exp_dmem[$];
  alu_t   exp_alu[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic missing(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT produced an item with nothing expected", name);
  endtask

  // Instruction memory: zero-wait ack.
  initial begin
    imem_ack = 1'b0;
    imem_data = 16'h0;
    forever begin
      @(posedge clk); #1;
      imem_ack = imem_req;
      imem_data = prog[imem_addr];
    end
  end

  // Data memory: per-transaction stall taken from dstall[].
  initial begin
    int left;
    bit busy;
    left = 0;
    busy = 0;
    dmem_ack = 1'b0;
    dmem_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!dmem_req) begin
        busy = 0;
        dmem_ack = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1;
          left = zero_stall ? 0 : dstall[dcnt % 2048];
          dcnt++;
        end
        if (left == 0) begin
          dmem_ack = 1'b1;
          dmem_rdata = dmem_mem[dmem_addr];
          if (dmem_we) dmem_mem[dmem_addr] = dmem_wdata;
        end else begin
          dmem_ack = 1'b0;
          left--;
        end
      end
    end
  end

  // Fetch monitor: architectural state and pc at each fetch handshake, plus latency.
  initial begin
    fetch_t f;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en && imem_req && imem_ack) begin
        if (exp_fetch.size() == 0) missing("fetch");
        else begin
          f = exp_fetch.pop_front();
          chk("fetch_addr", imem_addr, f.pc);
          chk("pc", pc, f.pc);
          chk("reg_a", reg_a, f.a);
          chk("reg_b", reg_b, f.b);
          chk("illegal", illegal, f.ill);
          if (f.gap != 0) chk("latency", cyc - last_fetch, f.gap);
          last_fetch = cyc;
          fetched++;
          if (fetched == K) mon_en = 0;
        end
      end
    end
  end

  // ALU issue monitor: every non-NOP opcode is a single-cycle pulse with current A/B.
  initial begin
    logic [5:0] prev_op;
    alu_t e;
    prev_op = NOP;
    forever begin
      @(negedge clk);
      if (mon_en && alu_opcode != NOP) begin
        chk("alu_one_cycle", prev_op, NOP);
        if (exp_alu.size() == 0) missing("alu_issue");
        else begin
          e = exp_alu.pop_front();
          chk("alu_opcode", alu_opcode, e.op);
          chk("alu_in1", alu_in1, {2'b00, e.a});
          chk("alu_in2", alu_in2, {2'b00, e.b});
        end
      end
      prev_op = alu_opcode;
    end
  end

  // Data memory monitor: request fields checked every cycle while held, popped on ack.
  initial begin
    dmem_t d;
    forever begin
      @(negedge clk);
      if (mon_en && dmem_req) begin
        if (exp_dmem.size() == 0) missing("dmem_req");
        else begin
          d = exp_dmem[0];
          chk("dmem_we", dmem_we, d.we);
          chk("dmem_addr", dmem_addr, d.addr);
          if (d.we) chk("dmem_wdata", dmem_wdata, d.wdata);
          if (dmem_ack) void'(exp_dmem.pop_front());
        end
      end
    end
  end

  initial begin
    logic [9:0] rpc;
    logic [7:0] ra, rb;
    logic       rill;
    logic [5:0] op;
    logic [9:0] opd;
    int         gap, m, k;
    fetch_t     f;
    dmem_t      d;
    alu_t       e;

    // Program: directed prefix, random body, NOP at the top address for the wrap.
    prog[0] = {LDCA, 10'h012};
    prog[1] = {LDCB, 10'h034};
    prog[2] = {ADDA, 10'h000};
    prog[3] = {LDCA, 10'h0F0};
    prog[4] = {LDCB, 10'h020};
    prog[5] = {ADDB, 10'h000};
    prog[6] = {LDCA, 10'h05A};
    prog[7] = {STA,  10'h005};
    prog[8] = {LDB,  10'h3FF};
    prog[9] = {6'h3F, 10'h000};
    for (int i = 10; i < 1023; i++) begin
      k = $urandom_range(0, 9);
      if (k < 9) op = legal_ops[k];
      else       op = 6'($urandom_range(9, 63));
      prog[i] = {op, 10'($urandom)};
    end
    prog[1023] = {NOP, 10'($urandom)};
    for (int i = 0; i < 1024; i++) dmem_mem[i] = 8'($urandom);
    dmem_mem[10'h3FF] = 8'hC3;
    for (int i = 0; i < 1024; i++) ref_mem[i] = dmem_mem[i];
    for (int i = 0; i < 2048; i++) dstall[i] = $urandom_range(0, 3);
    dstall[0] = 3;
    dstall[1] = 2;

    // Instruction-level reference model.
    rpc = 10'h000; ra = 8'h00; rb = 8'h00; rill = 1'b0; gap = 0; m = 0;
    for (int j = 0; j < K; j++) begin
      f.pc = rpc; f.a = ra; f.b = rb; f.ill = rill; f.gap = gap;
      exp_fetch.push_back(f);
      if (j == K - 1) break;
      op = prog[rpc][15:10];
      opd = prog[rpc][9:0];
      gap = 4;
      e.op = op; e.a = ra; e.b = rb;
      if (op inside {LDCA, LDCB, LDA, LDB, STA, STB, ADDA, ADDB}) exp_alu.push_back(e);
      d.we = op inside {STA, STB};
      d.addr = opd;
      d.wdata = (op == STB) ? rb : ra;
      if (op inside {LDA, LDB, STA, STB}) begin
        exp_dmem.push_back(d);
        gap = 5 + dstall[m];
        m++;
      end
      case (op)
        LDCA: ra = opd[7:0];
        LDCB: rb = opd[7:0];
        ADDA: ra = 8'((int'(ra) + int'(rb)) % 256);
        ADDB: rb = 8'((int'(ra) + int'(rb)) % 256);
        STA:  ref_mem[opd] = ra;
        STB:  ref_mem[opd] = rb;
        LDA:  ra = ref_mem[opd];
        LDB:  rb = ref_mem[opd];
        NOP:  ;
        default: rill = 1'b1;
      endcase
      rpc = 10'((int'(rpc) + 1) % 1024);
    end

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_alu_opcode", alu_opcode, NOP);
    chk("rst_pc", pc, 0);
    chk("rst_reg_a", reg_a, 0);
    chk("rst_reg_b", reg_b, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    mon_en = 1;
    @(posedge clk); #1 reset = 1'b1;

    for (int i = 0; i < 20000 && fetched < K; i++) @(posedge clk);
    mon_en = 0;
    chk("all_fetches_done", fetched, K);
    chk("alu_queue_drained", exp_alu.size(), 0);
    chk("dmem_queue_drained", exp_dmem.size(), 0);

    // Reset while LDA is in MEM with its ack already presented.
    zero_stall = 1;
    @(negedge clk); reset = 1'b0;
    prog[0] = {LDCA, 10'h011};
    prog[1] = {LDA, 10'h010};
    dmem_mem[10'h010] = 8'h77;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 50 && !(dmem_req && dmem_ack); i++) @(negedge clk);
    chk("lda_reached_mem", dmem_req && dmem_ack, 1);
    chk("lda_dmem_we", dmem_we, 0);
    chk("lda_dmem_addr", dmem_addr, 10'h010);
    chk("lda_pre_reg_a", reg_a, 8'h11);
    reset = 1'b0;
    #1;
    chk("midrst_dmem_req", dmem_req, 0);
    chk("midrst_imem_req", imem_req, 0);
    chk("midrst_reg_a", reg_a, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_illegal", illegal, 0);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    chk("post_rst_fetch", imem_req, 1);
    chk("post_rst_addr", imem_addr, 0);
    chk("post_rst_reg_a", reg_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
